// File: rtl/mips_cpu_regfile_write_arbiter.sv
// Register-file write-port arbiter: two one-entry writeback buffers (ALU, load)
// share one registered write port, with age ordering, starvation relief and a pending-write mask.
module mips_cpu_regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic [31:0] pending_mask
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // One-hot register decode; register 0 is never tracked as pending.
  function automatic logic [31:0] reg_onehot(input logic valid, input logic [4:0] idx);
    logic [31:0] v;
    v = 32'd0;
    if (valid && (idx != 5'd0)) begin
      v[idx] = 1'b1;
    end else begin
      v = 32'd0;
    end
    return v;
  endfunction

  logic        ready_en_r;
  logic        alu_full_r;
  logic [4:0]  alu_reg_r;
  logic [31:0] alu_data_r;
  logic        mem_full_r;
  logic [4:0]  mem_reg_r;
  logic [31:0] mem_data_r;
  logic        mem_older_r;
  logic [3:0]  starve_cnt_r;
  logic        rf_we_r;
  logic [4:0]  rf_reg_r;
  logic [31:0] rf_data_r;
  logic [31:0] pending_r;

  logic        alu_grant_s;
  logic        mem_grant_s;
  logic        alu_ready_s;
  logic        mem_ready_s;
  logic        alu_load_s;
  logic        mem_load_s;
  logic        alu_full_nx;
  logic [4:0]  alu_reg_nx;
  logic [31:0] alu_data_nx;
  logic        mem_full_nx;
  logic [4:0]  mem_reg_nx;
  logic [31:0] mem_data_nx;
  logic        mem_older_nx;
  logic [3:0]  starve_cnt_nx;
  logic        rf_we_nx;
  logic [4:0]  rf_reg_nx;
  logic [31:0] rf_data_nx;
  logic [31:0] pending_nx;

  // Grant selection from buffer state only, so valid never reaches ready combinationally.
  always_comb begin
    alu_grant_s = 1'b0;
    mem_grant_s = 1'b0;
    if (alu_full_r && mem_full_r) begin
      if (alu_reg_r == mem_reg_r) begin
        if (mem_older_r) begin
          mem_grant_s = 1'b1;
        end else begin
          alu_grant_s = 1'b1;
        end
      end else if (starve_cnt_r == STARVE_MAX) begin
        alu_grant_s = 1'b1;
      end else begin
        mem_grant_s = 1'b1;
      end
    end else if (alu_full_r) begin
      alu_grant_s = 1'b1;
    end else if (mem_full_r) begin
      mem_grant_s = 1'b1;
    end else begin
      alu_grant_s = 1'b0;
      mem_grant_s = 1'b0;
    end
  end

  assign alu_ready_s = ready_en_r & (~alu_full_r | alu_grant_s);
  assign mem_ready_s = ready_en_r & (~mem_full_r | mem_grant_s);
  // Writes to r0 complete the handshake but never occupy a buffer.
  assign alu_load_s  = alu_valid & alu_ready_s & (alu_reg != 5'd0);
  assign mem_load_s  = mem_valid & mem_ready_s & (mem_reg != 5'd0);

  assign alu_ready       = alu_ready_s;
  assign mem_ready       = mem_ready_s;
  assign rf_write_enable = rf_we_r;
  assign rf_write_reg    = rf_reg_r;
  assign rf_write_data   = rf_data_r;
  assign pending_mask    = pending_r;

  // Next-state for both holding buffers (a grant and a reload may share one edge).
  always_comb begin
    alu_full_nx = alu_full_r;
    alu_reg_nx  = alu_reg_r;
    alu_data_nx = alu_data_r;
    mem_full_nx = mem_full_r;
    mem_reg_nx  = mem_reg_r;
    mem_data_nx = mem_data_r;
    if (alu_load_s) begin
      alu_full_nx = 1'b1;
      alu_reg_nx  = alu_reg;
      alu_data_nx = alu_data;
    end else if (alu_grant_s) begin
      alu_full_nx = 1'b0;
    end else begin
      alu_full_nx = alu_full_r;
    end
    if (mem_load_s) begin
      mem_full_nx = 1'b1;
      mem_reg_nx  = mem_reg;
      mem_data_nx = mem_data;
    end else if (mem_grant_s) begin
      mem_full_nx = 1'b0;
    end else begin
      mem_full_nx = mem_full_r;
    end
  end

  // Age bit and starvation counter next-state.
  always_comb begin
    mem_older_nx = mem_older_r;
    if (alu_load_s && mem_load_s) begin
      mem_older_nx = 1'b1;
    end else if (alu_load_s && mem_full_r && !mem_grant_s) begin
      mem_older_nx = 1'b1;
    end else if (mem_load_s && alu_full_r && !alu_grant_s) begin
      mem_older_nx = 1'b0;
    end else begin
      mem_older_nx = mem_older_r;
    end
    starve_cnt_nx = 4'd0;
    if (alu_full_r && !alu_grant_s) begin
      if (starve_cnt_r >= STARVE_MAX) begin
        starve_cnt_nx = STARVE_MAX;
      end else begin
        starve_cnt_nx = starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_nx = 4'd0;
    end
  end

  // Write-port next-state and the pending mask as it will look after the edge.
  always_comb begin
    rf_we_nx   = 1'b0;
    rf_reg_nx  = rf_reg_r;
    rf_data_nx = rf_data_r;
    if (alu_grant_s) begin
      rf_we_nx   = 1'b1;
      rf_reg_nx  = alu_reg_r;
      rf_data_nx = alu_data_r;
    end else if (mem_grant_s) begin
      rf_we_nx   = 1'b1;
      rf_reg_nx  = mem_reg_r;
      rf_data_nx = mem_data_r;
    end else begin
      rf_we_nx   = 1'b0;
    end
    pending_nx = reg_onehot(alu_full_nx, alu_reg_nx)
               | reg_onehot(mem_full_nx, mem_reg_nx)
               | reg_onehot(rf_we_nx, rf_reg_nx);
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_r   <= 1'b0;
      alu_full_r   <= 1'b0;
      alu_reg_r    <= 5'd0;
      alu_data_r   <= 32'd0;
      mem_full_r   <= 1'b0;
      mem_reg_r    <= 5'd0;
      mem_data_r   <= 32'd0;
      mem_older_r  <= 1'b0;
      starve_cnt_r <= 4'd0;
      rf_we_r      <= 1'b0;
      rf_reg_r     <= 5'd0;
      rf_data_r    <= 32'd0;
      pending_r    <= 32'd0;
    end else begin
      ready_en_r   <= 1'b1;
      alu_full_r   <= alu_full_nx;
      alu_reg_r    <= alu_reg_nx;
      alu_data_r   <= alu_data_nx;
      mem_full_r   <= mem_full_nx;
      mem_reg_r    <= mem_reg_nx;
      mem_data_r   <= mem_data_nx;
      mem_older_r  <= mem_older_nx;
      starve_cnt_r <= starve_cnt_nx;
      rf_we_r      <= rf_we_nx;
      rf_reg_r     <= rf_reg_nx;
      rf_data_r    <= rf_data_nx;
      pending_r    <= pending_nx;
    end
  end

endmodule

// File: tb/tb_mips_cpu_regfile_write_arbiter.sv
// Directed table-driven bench for mips_cpu_regfile_write_arbiter plus
// hand-written starvation and mid-operation reset sequences.
module tb_mips_cpu_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] pending_mask;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        exp_ar;
    logic        exp_mr;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic [31:0] exp_mask;
  } vec_t;

  vec_t vecs[19];
  int   exp_seq[6];

  mips_cpu_regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    //            av    ar     ad          mv    mr      md        ar?   mr?   we    reg    data        mask
    vecs[0]  = '{1'b1, 5'd5,  32'h11,    1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    32'h20};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 5'd5,  32'h11,   32'h20};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd5,  32'h11,   32'h0};
    vecs[3]  = '{1'b1, 5'd4,  32'hBB,    1'b1, 5'd3,  32'hAA,   1'b1, 1'b1, 1'b0, 5'd5,  32'h11,   32'h18};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd3,  32'hAA,   32'h18};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 5'd4,  32'hBB,   32'h10};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd4,  32'hBB,   32'h0};
    vecs[7]  = '{1'b1, 5'd0,  32'h55,    1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd4,  32'hBB,   32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd4,  32'hBB,   32'h0};
    vecs[9]  = '{1'b1, 5'd9,  32'h1,     1'b1, 5'd10, 32'h3,    1'b1, 1'b1, 1'b0, 5'd4,  32'hBB,   32'h600};
    vecs[10] = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd9,  32'h2,    1'b0, 1'b1, 1'b1, 5'd10, 32'h3,    32'h600};
    vecs[11] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd9,  32'h1,    32'h200};
    vecs[12] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 5'd9,  32'h2,    32'h200};
    vecs[13] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd9,  32'h2,    32'h0};
    vecs[14] = '{1'b1, 5'd1,  32'h100,   1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd9,  32'h2,    32'h2};
    vecs[15] = '{1'b1, 5'd2,  32'h200,   1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 5'd1,  32'h100,  32'h6};
    vecs[16] = '{1'b1, 5'd3,  32'h300,   1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 5'd2,  32'h200,  32'hC};
    vecs[17] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 5'd3,  32'h300,  32'h8};
    vecs[18] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd3,  32'h300,  32'h0};
    exp_seq = '{11, 12, 13, 14, 7, 15};

    // Reset state
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst we", 32'(rf_write_enable), 32'd0);
    chk("rst reg", 32'(rf_write_reg), 32'd0);
    chk("rst data", rf_write_data, 32'd0);
    chk("rst mask", pending_mask, 32'd0);
    chk("rst alu_ready", 32'(alu_ready), 32'd0);
    chk("rst mem_ready", 32'(mem_ready), 32'd0);
    step();
    step();
    chk("rst held alu_ready", 32'(alu_ready), 32'd0);
    chk("rst held mem_ready", 32'(mem_ready), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("post-rst alu_ready", 32'(alu_ready), 32'd1);
    chk("post-rst mem_ready", 32'(mem_ready), 32'd1);

    // Table: single write, same-edge pair, r0 discard, same-reg ordering, streaming
    for (int i = 0; i < 19; i++) begin
      alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
      #1;
      chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].exp_ar));
      chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].exp_mr));
      step();
      chk($sformatf("v%0d we", i), 32'(rf_write_enable), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d reg", i), 32'(rf_write_reg), 32'(vecs[i].exp_reg));
      chk($sformatf("v%0d data", i), rf_write_data, vecs[i].exp_data);
      chk($sformatf("v%0d mask", i), pending_mask, vecs[i].exp_mask);
    end
    idle();

    // Starvation: mem streams distinct registers, ALU r7 must win 5 edges after filling
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b1; mem_reg = 5'd11; mem_data = 32'h1011;
    step();
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
    mem_reg = 5'd12; mem_data = 32'h1012;
    for (int n = 1; n <= 6; n++) begin
      acc = mem_ready;
      step();
      chk($sformatf("starve n%0d we", n), 32'(rf_write_enable), 32'd1);
      chk($sformatf("starve n%0d reg", n), 32'(rf_write_reg), 32'(exp_seq[n-1]));
      if (n == 5) begin
        chk("starve alu data", rf_write_data, 32'h77);
      end
      if (acc) begin
        mem_reg = mem_reg + 5'd1;
        mem_data = mem_data + 32'd1;
      end
    end
    idle();
    step();
    chk("starve drain reg", 32'(rf_write_reg), 32'd16);
    step();
    step();
    chk("starve drain mask", pending_mask, 32'd0);
    chk("starve drain we", 32'(rf_write_enable), 32'd0);

    // Reset mid-operation with both buffers full and a write on the port
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'hA20;
    mem_valid = 1'b1; mem_reg = 5'd21; mem_data = 32'hA21;
    step();
    alu_valid = 1'b0;
    mem_reg = 5'd22; mem_data = 32'hA22;
    step();
    chk("pre-rst we", 32'(rf_write_enable), 32'd1);
    chk("pre-rst mask", pending_mask, 32'h0070_0000);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid-rst we", 32'(rf_write_enable), 32'd0);
    chk("mid-rst reg", 32'(rf_write_reg), 32'd0);
    chk("mid-rst data", rf_write_data, 32'd0);
    chk("mid-rst mask", pending_mask, 32'd0);
    chk("mid-rst alu_ready", 32'(alu_ready), 32'd0);
    chk("mid-rst mem_ready", 32'(mem_ready), 32'd0);
    idle();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("post-rst%0d we", k), 32'(rf_write_enable), 32'd0);
      chk($sformatf("post-rst%0d mask", k), pending_mask, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_regfile_write_arbiter.md
# mips_cpu_regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU result path and the memory-load return path. Each requester has a one-entry holding buffer with a valid/ready handshake. A registered arbiter picks one buffer per cycle and drives the register file's write-enable, address and data. A pending-write mask lets the decoder stall on registers whose value is still in flight.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the ALU buffer may be full and ungranted before it is forced to win; legal range 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU buffer can accept.
- alu_reg  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load buffer can accept.
- mem_reg  in  5  load destination register.
- mem_data  in  32  load data.
- rf_write_enable  out  1  register file write enable (registered).
- rf_write_reg  out  5  register file write address (registered).
- rf_write_data  out  32  register file write data (registered).
- pending_mask  out  32  bit r set while a write to register r is buffered or on the rf_* outputs.

## Operation
- Transfer on a port when valid && ready at a rising edge; reg/data are captured into that port's buffer.
- A request with reg == 0 completes the handshake but is discarded. The buffer stays empty and no write is issued.
- ready = !buffer_full || buffer_granted_this_cycle. Grant depends only on buffer state, never on either valid input, so there is no combinational valid->ready path.
- Arbitration applies only when both buffers are full:
  - Same target register: the older entry wins. If both were loaded on the same edge, mem is older.
  - Different targets: mem wins, unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
- Arbitration when exactly one buffer is full: that buffer wins. When none is full: no grant.
- starve_cnt (4 bits):
  - increments each cycle the ALU buffer is full and not granted;
  - clears when the ALU buffer is granted or empty;
  - saturates at STARVE_LIMIT.
- Age: an age bit records which buffer was loaded first and is updated whenever a buffer loads while the other is full.
- On grant: the granted buffer clears at the edge, and rf_write_enable/reg/data load from it at the same edge.
- With no grant: rf_write_enable loads 0, and rf_write_reg/data hold their previous values.
- pending_mask = decode(alu buffer reg if full) | decode(mem buffer reg if full) | decode(rf_write_reg if rf_write_enable). Bit 0 is always 0.

## Timing
- Reset asserted: all outputs are forced immediately (asynchronously).
  - Buffers empty, age and starve_cnt cleared.
  - rf_write_enable=0, rf_write_reg=0, rf_write_data=0, pending_mask=0.
  - alu_ready=mem_ready=0 while reset is low; both rise in the first cycle after deassertion.
- Reset mid-operation: buffered and output-registered writes are discarded. No write enable is ever asserted for them.
- Latency:
  - accept at edge E0 -> granted at E1 at the earliest -> rf_write_enable high during cycle E1..E2 -> register file commits at E2.
  - Minimum accept-to-commit is 2 edges.
- Throughput:
  - one write per cycle total;
  - a lone requester streaming every cycle sustains 1/cycle with ready held high.
- Under mem saturation, ALU is granted at the latest STARVE_LIMIT+1 cycles after its buffer fills.
- Same-register ordering: commits to one register occur in acceptance order across ports. On a same-edge tie, mem commits first.
- Simultaneous grant and new accept on the same port at one edge is legal: the buffer reloads, with no bubble.

## Test plan
- Reset release, then alu_valid=1, alu_reg=5, alu_data=0x11 for one cycle -> rf_write_enable high one cycle, 2 edges after accept, reg=5, data=0x11. pending_mask[5] is high from the accept edge until rf_write_enable falls.
- Both ports request on the same edge (mem reg 3/0xAA, alu reg 4/0xBB) -> mem written first, ALU in the following cycle. Ready on each port behaves per the formula.
- mem_valid held high continuously with distinct registers, ALU buffer full with reg 7 -> ALU granted exactly STARVE_LIMIT+1 (=5) cycles after its buffer fills; mem resumes afterwards.
- ALU accepted reg 9/0x1 one edge before mem reg 9/0x2, with both buffers held full -> commits are 0x1 then 0x2. Final register 9 = 0x2 despite mem priority.
- alu_reg=0 with valid -> handshake completes, no rf_write_enable, pending_mask stays 0.
- Buffers full and rf_write_enable high, then reset driven low mid-cycle -> all outputs 0 immediately; no write occurs after reset release.
